// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU: op encodings, FSM states
// and the bit positions of the NZCV flags.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_ORR  = 4'b0011,
        OP_BIC  = 4'b0100,
        OP_EOR  = 4'b0101,
        OP_MOV  = 4'b0110,
        OP_MUL  = 4'b1000,
        OP_UDIV = 4'b1001,
        OP_UREM = 4'b1010
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU slice: add/sub/logic/move results with NZCV flags,
// plus the divide-by-zero shortcut results for UDIV/UREM.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic             carry;
    logic             ovf;

    always_comb begin
        sub      = (alu_op_t'(op) == OP_SUB);
        b_eff    = sub ? ~b : b;
        sum_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

        // Unknown codes fall through to the ADD defaults below.
        result = sum_full[WIDTH-1:0];
        carry  = sum_full[WIDTH];
        ovf    = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum_full[WIDTH-1]);

        case (alu_op_t'(op))
            OP_AND: begin
                result = a & b;
                carry  = 1'b0;
                ovf    = 1'b0;
            end
            OP_ORR: begin
                result = a | b;
                carry  = 1'b0;
                ovf    = 1'b0;
            end
            OP_BIC: begin
                result = a & ~b;
                carry  = 1'b0;
                ovf    = 1'b0;
            end
            OP_EOR: begin
                result = a ^ b;
                carry  = 1'b0;
                ovf    = 1'b0;
            end
            OP_MOV: begin
                result = b;
                carry  = 1'b0;
                ovf    = 1'b0;
            end
            OP_MUL: begin
                result = '0;
                carry  = 1'b0;
                ovf    = 1'b0;
            end
            // Only consumed when b==0; the iterative divider handles the rest.
            OP_UDIV: begin
                result = '1;
                carry  = 1'b0;
                ovf    = 1'b1;
            end
            OP_UREM: begin
                result = a;
                carry  = 1'b0;
                ovf    = 1'b1;
            end
            default: ;
        endcase

        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops via alu_core, shift-add multiply and restoring
// divide one bit per cycle, valid/ready handshake on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    localparam int CW = $clog2(WIDTH) + 1;

    alu_state_t       state, state_nxt;
    alu_op_t          op_r, op_nxt;
    logic [WIDTH-1:0] a_sh, a_nxt;
    logic [WIDTH-1:0] b_sh, b_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] res_r, res_nxt;
    logic [3:0]       flags_r, flags_nxt;

    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;

    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] fin_res;
    logic [3:0]       fin_flags;
    logic             last;
    logic             is_div;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (ALUControl),
        .a      (a),
        .b      (b),
        .result (core_result),
        .flags  (core_flags)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign Result    = res_r;
    assign ALUFlags  = flags_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_r    <= OP_ADD;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            res_r   <= '0;
            flags_r <= '0;
        end else begin
            state   <= state_nxt;
            op_r    <= op_nxt;
            a_sh    <= a_nxt;
            b_sh    <= b_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            res_r   <= res_nxt;
            flags_r <= flags_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_r;
        a_nxt     = a_sh;
        b_nxt     = b_sh;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        res_nxt   = res_r;
        flags_nxt = flags_r;

        mul_sum = acc + (b_sh[0] ? a_sh : '0);

        // Divide: a_sh shifts the dividend out at the top and the quotient in at
        // the bottom; acc holds the partial remainder.
        div_trial = {acc, a_sh[WIDTH-1]};
        div_diff  = div_trial - {1'b0, b_sh};
        div_ok    = ~div_diff[WIDTH];
        div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
        div_quo   = {a_sh[WIDTH-2:0], div_ok};

        last   = (cnt == CW'(WIDTH - 1));
        is_div = (alu_op_t'(ALUControl) == OP_UDIV) || (alu_op_t'(ALUControl) == OP_UREM);

        if (state == MUL)
            fin_res = mul_sum;
        else
            fin_res = (op_r == OP_UREM) ? div_rem : div_quo;
        fin_flags         = '0;
        fin_flags[FLAG_N] = fin_res[WIDTH-1];
        fin_flags[FLAG_Z] = (fin_res == '0);

        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_nxt  = alu_op_t'(ALUControl);
                    a_nxt   = a;
                    b_nxt   = b;
                    acc_nxt = '0;
                    cnt_nxt = '0;
                    if (alu_op_t'(ALUControl) == OP_MUL) begin
                        state_nxt = MUL;
                    end else if (is_div && (b != '0)) begin
                        state_nxt = DIV;
                    end else begin
                        state_nxt = DONE;
                        res_nxt   = core_result;
                        flags_nxt = core_flags;
                    end
                end
            end
            MUL: begin
                acc_nxt = mul_sum;
                a_nxt   = a_sh << 1;
                b_nxt   = b_sh >> 1;
                cnt_nxt = cnt + CW'(1);
                if (last) begin
                    state_nxt = DONE;
                    res_nxt   = fin_res;
                    flags_nxt = fin_flags;
                end
            end
            DIV: begin
                acc_nxt = div_rem;
                a_nxt   = div_quo;
                cnt_nxt = cnt + CW'(1);
                if (last) begin
                    state_nxt = DONE;
                    res_nxt   = fin_res;
                    flags_nxt = fin_flags;
                end
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc (WIDTH=32) against an arithmetic
// reference model of the op set, latency and handshake.
module tb_alu_mc;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ALUControl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;

    int checks   = 0;
    int failures = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .ALUFlags   (ALUFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: result, flags and accept-to-valid latency from plain arithmetic.
    task automatic model_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] r, output logic [3:0] f, output int lat);
        logic [63:0] wide;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        lat = 1;
        case (op)
            4'd1: begin
                r = x - y;
                c = (x >= y);
                v = (x[31] != y[31]) && (r[31] != x[31]);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x & ~y;
            4'd5: r = x ^ y;
            4'd6: r = y;
            4'd8: begin
                wide = {32'd0, x} * {32'd0, y};
                r = wide[31:0];
                lat = 33;
            end
            4'd9: begin
                if (y == 0) begin r = 32'hFFFF_FFFF; v = 1'b1; end
                else begin r = x / y; lat = 33; end
            end
            4'd10: begin
                if (y == 0) begin r = x; v = 1'b1; end
                else begin r = x % y; lat = 33; end
            end
            default: begin
                wide = {32'd0, x} + {32'd0, y};
                r = wide[31:0];
                c = wide[32];
                v = (x[31] == y[31]) && (r[31] != x[31]);
            end
        endcase
        f = {r[31], (r == 0), c, v};
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] opa, input logic [31:0] opb,
                          input int hold);
        logic [31:0] er;
        logic [3:0]  ef;
        int          el;
        int          n;
        logic        busy_ok;
        model_op(op, opa, opb, er, ef, el);
        @(negedge clk);
        a = opa;
        b = opb;
        ALUControl = op;
        in_valid = 1'b1;
        check_eq("accept_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        ALUControl = 4'($urandom);
        n = 1;
        busy_ok = 1'b1;
        while (n <= 100) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            n++;
        end
        check_eq("latency", n, el);
        check_eq("busy_in_ready_low", busy_ok, 1);
        check_eq("result", Result, er);
        check_eq("flags", ALUFlags, ef);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            ALUControl = 4'($urandom);
            @(negedge clk);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_result", Result, er);
            check_eq("hold_flags", ALUFlags, ef);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("post_hs_valid", out_valid, 0);
        check_eq("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic        seen_valid;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        ALUControl = '0;
        #12;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_result", Result, 0);
        check_eq("rst_flags", ALUFlags, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(4'b0001, 32'd5, 32'd5, 0);
        run_op(4'b0000, 32'h7FFF_FFFF, 32'd1, 0);
        run_op(4'b1000, 32'h0001_0003, 32'd5, 0);
        run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(4'b1001, 32'd100, 32'd7, 0);
        run_op(4'b1010, 32'd100, 32'd7, 0);
        run_op(4'b1001, 32'h8000_0000, 32'd1, 0);
        run_op(4'b1001, 32'd9, 32'd0, 0);
        run_op(4'b1010, 32'd9, 32'd0, 0);
        run_op(4'b0000, 32'd1, 32'd2, 5);
        run_op(4'b1111, 32'h1234_5678, 32'h0FED_CBA9, 1);

        // Abort a multiply mid-flight with an asynchronous reset.
        @(negedge clk);
        a = 32'h0001_0003;
        b = 32'd5;
        ALUControl = 4'b1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_result", Result, 0);
        check_eq("midrst_flags", ALUFlags, 0);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check_eq("midrst_no_stale_valid", seen_valid, 0);
        run_op(4'b0000, 32'd2, 32'd3, 0);

        for (int i = 0; i < 200; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = ra;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU, the successor of the single-cycle pipeline ALU. It adds width generality, iterative unsigned multiply, divide and remainder, and a valid/ready handshake on both sides. It sits in the execute stage and stalls the pipeline through in_ready/out_valid while an iterative op is in flight. Single-cycle ops keep the existing encodings and NZCV flag semantics.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept an op
a  in  WIDTH  operand A
b  in  WIDTH  operand B
ALUControl  in  4  operation select
out_valid  out  1  Result/ALUFlags valid
out_ready  in  1  consumer takes result
Result  out  WIDTH  registered result
ALUFlags  out  4  registered {N,Z,C,V}

Behaviour:
- One clock; reset is asynchronous and active-high: clk and reset as named above.
- Reset values: state IDLE; in_ready=1; out_valid=0; Result=0; ALUFlags=0; internal registers and counter = 0.
- Op encoding:
  - 0000 ADD, 0001 SUB (a+~b+1), 0010 AND, 0011 ORR, 0100 BIC (a&~b), 0101 EOR, 0110 MOV (b).
  - 1000 MUL (low WIDTH bits of unsigned a*b), 1001 UDIV, 1010 UREM.
  - All other codes execute as ADD.
- Accept: in_valid && in_ready at edge t. a, b and op are captured; input changes after that are ignored until the next accept.
- States: IDLE, MUL, DIV, DONE. in_ready=1 only in IDLE.
- IDLE transitions on accept:
  - Single-cycle op, or UDIV/UREM with b==0: go to DONE with the result registered. out_valid=1 from t+1 (latency 1).
  - MUL: go to MUL with count=0. Shift-add: acc += (b_sh[0] ? a_sh : 0), a_sh<<=1, b_sh>>=1, one bit per cycle. After WIDTH cycles go to DONE. out_valid from t+WIDTH+1.
  - UDIV/UREM with b!=0: go to DIV. Restoring division, one quotient bit per cycle MSB-first, using a WIDTH+1-bit remainder trial subtract. After WIDTH cycles go to DONE. out_valid from t+WIDTH+1.
- Counter width is $clog2(WIDTH)+1. Terminal count is WIDTH-1 in the last iteration cycle.
- DONE:
  - out_valid=1; Result and ALUFlags stay stable while out_ready=0.
  - out_ready=1 returns to IDLE; in_ready rises the next cycle. Peak throughput is one op per 2 cycles.
  - out_valid drops the cycle after the handshake.
- Flags:
  - N = Result[WIDTH-1]; Z = (Result==0).
  - ADD/SUB/default: C = carry out of bit WIDTH-1. V = ~(a[W-1]^b[W-1]^sub) & (a[W-1]^sum[W-1]).
  - Logic, MOV, MUL: C=0, V=0.
  - UDIV/UREM: C=0. V=1 only on divide-by-zero, in which case UDIV gives Result = all ones and UREM gives Result = a.
- Widths: all arithmetic is unsigned modulo 2^WIDTH. MUL high bits are discarded.
- Reset mid-operation: asserting reset in any state aborts immediately (async). All outputs take their reset values and no stale out_valid appears.
- in_valid while busy is ignored; no queuing.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_t: 4-bit enum of the op codes above.
  - alu_state_t: IDLE, MUL, DIV, DONE.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, alu_core: purely combinational, parametrised by WIDTH. Computes single-cycle ops, sum and the NZCV flags. alu_mc instantiates it and owns the FSM and the multiply/divide datapath.

Test Plan (WIDTH=32; t = accept edge):
1. SUB a=5, b=5 -> out_valid at t+1, Result=0x00000000, ALUFlags=0110. Then ADD 0x7FFFFFFF+0x00000001 -> Result=0x80000000, ALUFlags=1001.
2. MUL a=0x00010003, b=0x00000005 -> in_ready=0 during t+1..t+33, out_valid exactly at t+33, Result=0x0005000F, ALUFlags=0000. MUL 0xFFFFFFFF*0xFFFFFFFF -> Result=0x00000001.
3. UDIV 100/7 -> Result=14 at t+33. UREM 100/7 -> Result=2. UDIV 0x80000000/1 -> 0x80000000, ALUFlags=1000.
4. UDIV a=9, b=0 -> out_valid at t+1, Result=0xFFFFFFFF, ALUFlags=1001. UREM a=9, b=0 -> Result=9, ALUFlags=0001.
5. Backpressure: ADD 1+2 with out_ready=0 for 5 cycles -> Result=3 held, out_valid=1, in_ready=0, and a new in_valid with changed operands is ignored. Raising out_ready -> IDLE, in_ready=1 next cycle.
6. Assert reset asynchronously mid-edge at MUL iteration 10 -> outputs zero at once, out_valid never pulses. After release, ADD 2+3 -> Result=5 at t+1.
